// File: rtl/bt_pipe_out_fifo_if.sv
// Handshake and status bundle between a word producer / okBTPipeOut endpoint (master side)
// and the block-throttled output FIFO (slave side).
//   src_data/src_valid/src_ready       : producer valid/ready write channel
//   pipe_out_read/pipe_out_blockstrobe : endpoint ep_read / ep_blockstrobe
//   pipe_out_data/pipe_out_valid       : endpoint ep_datain / ep_ready
//   level                              : FIFO word count, 0..2^DEPTH_LOG2
//   err_flags                          : sticky {strobe_err, read_err}
interface bt_pipe_out_fifo_if #(
  parameter int unsigned DEPTH_LOG2 = 10
) ();
  logic [15:0]         src_data;
  logic                src_valid;
  logic                src_ready;
  logic                pipe_out_read;
  logic                pipe_out_blockstrobe;
  logic [15:0]         pipe_out_data;
  logic                pipe_out_valid;
  logic [DEPTH_LOG2:0] level;
  logic [1:0]          err_flags;

  modport master (
    output src_data, src_valid, pipe_out_read, pipe_out_blockstrobe,
    input  src_ready, pipe_out_data, pipe_out_valid, level, err_flags
  );

  modport slave (
    input  src_data, src_valid, pipe_out_read, pipe_out_blockstrobe,
    output src_ready, pipe_out_data, pipe_out_valid, level, err_flags
  );
endinterface

// File: rtl/bt_pipe_out_fifo.sv
// Block-throttled output buffer feeding an okBTPipeOut endpoint.
// Words from a producer are stored in a synchronous FIFO; ep_ready (pipe_out_valid) is only
// raised when a whole block of unreserved words is available. Each accepted block strobe
// reserves BLOCK_WORDS words; reads consume reservations. Protocol violations set sticky flags.
// Ports:
//   clk     : ti_clk, the only clock
//   reset_n : synchronous active-low reset
//   bus     : slave side of bt_pipe_out_fifo_if (write channel, endpoint signals, level, errors)
module bt_pipe_out_fifo #(
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter int unsigned BLOCK_WORDS = 256
) (
  input logic               clk,
  input logic               reset_n,
  bt_pipe_out_fifo_if.slave bus
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;
  localparam int unsigned LvlW  = DEPTH_LOG2 + 1;

  localparam logic [DEPTH_LOG2:0]   FullLevel = LvlW'(Depth);
  localparam logic [DEPTH_LOG2:0]   BlockLen  = LvlW'(BLOCK_WORDS);
  localparam logic [DEPTH_LOG2:0]   LvlOne    = LvlW'(1);
  localparam logic [DEPTH_LOG2-1:0] PtrOne    = DEPTH_LOG2'(1);

  typedef enum logic [0:0] {StIdle, StXfer} state_e;

  logic [15:0]           mem [Depth];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic [DEPTH_LOG2:0]   resv_q, resv_d;
  logic                  src_ready_q, src_ready_d;
  logic                  valid_q, valid_d;
  logic [15:0]           data_q;
  logic [1:0]            err_q, err_d;
  state_e                state_q, state_d;

  logic push, pop, strobe_ok, read_err, strobe_err, xfer_active;

  // Unreserved words currently held; never negative because resv <= level always.
  logic [DEPTH_LOG2:0] avail_now, avail_next;

  assign avail_now = level_q - resv_q;
  assign push      = bus.src_valid & src_ready_q;
  assign strobe_ok = bus.pipe_out_blockstrobe & (avail_now >= BlockLen);

  // ---------------------------------------------------------------------------------------------
  // Reservation FSM: StIdle <=> resv == 0, StXfer <=> resv > 0
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (strobe_ok) state_d = StXfer;
      StXfer: if (pop && (resv_q == LvlOne) && !strobe_ok) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    xfer_active = (state_q == StXfer);
    pop         = bus.pipe_out_read & xfer_active;
    read_err    = bus.pipe_out_read & ~xfer_active;
    strobe_err  = bus.pipe_out_blockstrobe & ~strobe_ok;
  end

  // ---------------------------------------------------------------------------------------------
  // Next-state datapath
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + LvlOne;
    end else if (pop && !push) begin
      level_d = level_q - LvlOne;
    end

    // Strobe check above used pre-update values; both updates may land together.
    resv_d = resv_q;
    if (strobe_ok) resv_d = resv_d + BlockLen;
    if (pop)       resv_d = resv_d - LvlOne;

    avail_next  = level_d - resv_d;
    valid_d     = (avail_next >= BlockLen);
    src_ready_d = (level_d != FullLevel);
    err_d       = err_q | {strobe_err, read_err};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      resv_q      <= '0;
      src_ready_q <= 1'b0;
      valid_q     <= 1'b0;
      err_q       <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
      level_q     <= level_d;
      resv_q      <= resv_d;
      src_ready_q <= src_ready_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Storage: synchronous-read RAM with registered output. A pop never targets the slot being
  // written on the same edge (that would need level 0 or full), so no bypass is required.
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= bus.src_data;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_q <= '0;
    end else if (pop) begin
      data_q <= mem[rd_ptr_q];
    end
  end

  assign bus.src_ready      = src_ready_q;
  assign bus.pipe_out_valid = valid_q;
  assign bus.pipe_out_data  = data_q;
  assign bus.level          = level_q;
  assign bus.err_flags      = err_q;

endmodule

// File: doc/bt_pipe_out_fifo.md
# bt_pipe_out_fifo

Block-throttled output buffer that sits directly upstream of the okBTPipeOut endpoint. It accepts 16-bit words from an on-chip producer, such as the pseudorandom generator, over a valid/ready handshake and stores them in a synchronous FIFO. It drives the endpoint's `ep_ready` only when a whole block can be served without underrun. It tracks per-block reservations from `ep_blockstrobe` and flags protocol violations with sticky error bits readable through a WireOut.

## Interface
- `DEPTH_LOG2`, default 10: FIFO depth is 2^DEPTH_LOG2 words (1024).
- `BLOCK_WORDS`, default 256: words per block-throttled transfer. Legal range is 1..2^DEPTH_LOG2.
- `clk`, in, 1: the `ti_clk` domain. This is the block's only clock.
- `reset_n`, in, 1: synchronous, active-low reset.
- `src_data`, in, 16: producer data.
- `src_valid`, in, 1: producer has a word.
- `src_ready`, out, 1: FIFO can accept a word.
- `pipe_out_read`, in, 1: connects to `ep_read`.
- `pipe_out_blockstrobe`, in, 1: connects to `ep_blockstrobe`.
- `pipe_out_data`, out, 16: connects to `ep_datain`.
- `pipe_out_valid`, out, 1: connects to `ep_ready`.
- `level`, out, DEPTH_LOG2+1: current word count, 0..2^DEPTH_LOG2.
- `err_flags`, out, 2: sticky errors. Bit 0 = read_err, bit 1 = strobe_err.

## Operation
- **Write:** a word is pushed when `src_valid` and `src_ready` are both high on a clock edge.
  - `src_ready` = (`level` != 2^DEPTH_LOG2), registered.
  - When the FIFO is full, `src_valid` is ignored and the producer holds its data.
- **Pointers:** read and write pointers are DEPTH_LOG2 bits wide and wrap modulo 2^DEPTH_LOG2. `level` is maintained as an up/down counter, never derived from the pointers.
- **Reservation counter `resv`** (width DEPTH_LOG2+1):
  - On `pipe_out_blockstrobe`, if (`level` − `resv`) ≥ BLOCK_WORDS, then `resv` += BLOCK_WORDS.
  - Otherwise `strobe_err` is set and `resv` is unchanged.
- **Read:** on `pipe_out_read` with `resv` > 0, one word is popped, `level` decrements, and `resv` decrements.
  - On `pipe_out_read` with `resv` = 0, nothing is popped, `read_err` is set, and `pipe_out_data` holds its value.
- **Simultaneous push and pop:** `level` is unchanged; both pointers advance.
- **Simultaneous strobe and read:** both reservation updates apply in the same cycle. The net change to `resv` is +BLOCK_WORDS−1. The strobe check uses the pre-update values.
- **Ready:** `pipe_out_valid` = ((`level` − `resv`) ≥ BLOCK_WORDS), registered from next-state values. It therefore reflects the current cycle's push, pop and strobe.
- **State machine:**
  - IDLE (`resv` = 0) moves to XFER on an accepted strobe.
  - XFER (`resv` > 0) returns to IDLE when the read that takes `resv` to 0 occurs, unless a strobe is accepted in the same cycle.
  - The state is observable for verification only through `resv` behaviour.
- **Error flags:** both bits of `err_flags` clear only on reset.

## Timing
- Reset values: `src_ready` = 0 during reset and 1 on the first cycle after reset deasserts. All other outputs are 0: `pipe_out_valid`, `pipe_out_data`, `level`, `err_flags`. Pointers and `resv` are also 0.
- Reset asserted mid-block discards the FIFO contents and any reservation. No error is flagged for reads that occur while `reset_n` = 0.
- Read latency is 1. Data for a read sampled on edge N is on `pipe_out_data` after edge N and holds until the next accepted read.
  - The memory is a synchronous-read RAM (block RAM inferable) with a registered output.
- Write-to-ready latency:
  - A push at edge N is counted in `level` after edge N.
  - `pipe_out_valid` can rise after edge N, 1 cycle after the push.
- Write-then-read of the same word: a word pushed at edge N may be popped at edge N+1 or later. A pop of that word is impossible earlier, because `resv` accounting requires it to be counted.
- Full boundary: with `level` = 2^DEPTH_LOG2, a simultaneous pop and `src_valid` does not push. `src_ready` rises one cycle after the pop.
- Empty boundary: `level` = 0 implies `resv` = 0, so any read sets `read_err`.

## Test plan
- **Fill and drain:** reset, then push 0..255 (BLOCK_WORDS = 256).
  - `pipe_out_valid` rises 1 cycle after the 256th push.
  - Strobe, then read 256 words: the data is 0..255 in order, `level` returns to 0, `pipe_out_valid` = 0, and `err_flags` = 0.
- **Full:** push 1024 words with reads idle.
  - `src_ready` = 0 and `level` = 1024.
  - Further `src_valid` adds nothing.
  - One block read restores `src_ready` and leaves `level` = 768.
- **Wrap-around:** run 10 blocks of pseudorandom data with continuous pushes and reads. Pointers wrap multiple times, the data matches the LFSR sequence, and there are no errors.
- **Violations:**
  - A strobe with `level` = 100 sets `err_flags[1]`.
  - A read with `resv` = 0 sets `err_flags[0]`, and `level` is unchanged.
  - Both flags stay set until reset.
- **Back-to-back blocks:** with `level` = 512, strobe, read 255 words, then assert strobe and the 256th read in the same cycle.
  - `resv` = 256 afterwards and no `strobe_err` is set.
  - `pipe_out_valid` = 0 until more data is pushed.
- **Reset mid-block:** pull `reset_n` low after 100 of 256 reads. All outputs return to 0 and the next block transfers cleanly.
